// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a GATE_CYCLES window of C_50Mhz.
// Define FREQ_METER_CONT_EN for free-running back-to-back measurements (start ignored).
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned GATE_W      = 26
) (
  input  logic             C_50Mhz,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_t             state;
  logic               s1, s2, s3, edge_det;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic               ovf;
  logic               go;

`ifdef FREQ_METER_CONT_EN
  logic unused_start;
  assign unused_start = start;
  assign go = 1'b1;
`else
  assign go = start;
`endif

  always_ff @(posedge C_50Mhz) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      edge_det <= 1'b0;
    end else begin
      s1       <= sig_in;
      s2       <= s1;
      s3       <= s2;
      edge_det <= s2 & ~s3;
    end
  end

  always_ff @(posedge C_50Mhz) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      freq     <= '0;
      overflow <= 1'b0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state    <= GATE;
            busy     <= 1'b1;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt + 1'b1;
          if (edge_det) begin
            if (edge_cnt != CNT_MAX)
              edge_cnt <= edge_cnt + 1'b1;
            // flag as soon as the count lands on all-ones; sticky until next window
            if (edge_cnt >= CNT_MAX - 1'b1)
              ovf <= 1'b1;
          end
          if (gate_cnt == GATE_LAST)
            state <= DONE;
        end
        DONE: begin
          done     <= 1'b1;
          freq     <= edge_cnt;
          overflow <= ovf;
`ifdef FREQ_METER_CONT_EN
          state    <= GATE;
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
`else
          state    <= IDLE;
          busy     <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
